// File: rtl/item_arbiter.sv
// Round-robin scheduler that shares one fixed-latency 8-bit item datapath among NREQ requesters.
// Holds a grant for up to MAX_BURST items and routes each datapath result back to its issuer by tag.
module item_arbiter_tag_stage #(
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_d,
  input  logic [IW-1:0] id_d,
  output logic          vld_q,
  output logic [IW-1:0] id_q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end
endmodule

module item_arbiter #(
  parameter int NREQ      = 4,
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*8-1:0]         req_item,
  output logic [NREQ-1:0]           req_ready,
  output logic [7:0]                dp_item_in,
  output logic                      dp_valid,
  input  logic [7:0]                dp_item_out,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [7:0]                rsp_item,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]               state, nxt_state;
  logic [IW-1:0]            ptr, nxt_ptr, holder, nxt_holder, last_id, dp_id, gnt_id, rot;
  logic [CW-1:0]            cnt, nxt_cnt;
  logic                     gnt;
  logic [IW:0]              pk;
  logic [NREQ-1:0][7:0]     req_arr;
  logic [LATENCY:0]         vld_pipe;
  logic [LATENCY:0][IW-1:0] id_pipe;

  assign req_arr = req_item;

  // Returns {found, id}: first set bit of v scanning p, p+1, ... mod NREQ.
  function automatic logic [IW:0] pick(input logic [NREQ-1:0] v, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] id, idx;
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(p) + i) % NREQ);
      if (!found && v[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
    return {found, id};
  endfunction

  assign rot = (holder == IW'(NREQ - 1)) ? '0 : holder + IW'(1);

  always_comb begin
    nxt_state  = state;
    nxt_ptr    = ptr;
    nxt_holder = holder;
    nxt_cnt    = cnt;
    gnt        = 1'b0;
    gnt_id     = '0;
    pk         = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          pk = pick(req_valid, ptr);
          if (pk[IW]) begin
            gnt        = 1'b1;
            gnt_id     = pk[IW-1:0];
            nxt_holder = pk[IW-1:0];
            nxt_cnt    = CW'(1);
            nxt_state  = HOLD;
          end
        end
      end
      HOLD: begin
        if (!enable) begin
          nxt_state = IDLE;
        end else if (req_valid[holder] && cnt < CW'(MAX_BURST)) begin
          gnt     = 1'b1;
          gnt_id  = holder;
          nxt_cnt = cnt + CW'(1);
        end else begin
          // Holder is masked out: either it dropped valid or its burst expired.
          nxt_ptr = rot;
          pk      = pick(req_valid & ~(NREQ'(1) << holder), rot);
          if (pk[IW]) begin
            gnt        = 1'b1;
            gnt_id     = pk[IW-1:0];
            nxt_holder = pk[IW-1:0];
            nxt_cnt    = CW'(1);
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign req_ready = (reset && gnt) ? (NREQ'(1) << gnt_id) : '0;
  assign grant_id  = !reset ? '0 : (gnt ? gnt_id : last_id);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      holder     <= '0;
      cnt        <= '0;
      last_id    <= '0;
      dp_item_in <= '0;
      dp_valid   <= 1'b0;
      dp_id      <= '0;
      rsp_valid  <= '0;
      rsp_item   <= '0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      holder   <= nxt_holder;
      cnt      <= nxt_cnt;
      dp_valid <= gnt;
      if (gnt) begin
        dp_item_in <= req_arr[gnt_id];
        dp_id      <= gnt_id;
        last_id    <= gnt_id;
      end
      rsp_valid <= vld_pipe[LATENCY] ? (NREQ'(1) << id_pipe[LATENCY]) : '0;
      if (vld_pipe[LATENCY]) rsp_item <= dp_item_out;
    end
  end

  // Tag line: stage LATENCY lines up with dp_item_out for the item it describes.
  assign vld_pipe[0] = dp_valid;
  assign id_pipe[0]  = dp_id;

  for (genvar k = 1; k <= LATENCY; k++) begin : g_tag
    item_arbiter_tag_stage #(.IW(IW)) u_stage (
      .clk   (clk),
      .reset (reset),
      .vld_d (vld_pipe[k-1]),
      .id_d  (id_pipe[k-1]),
      .vld_q (vld_pipe[k]),
      .id_q  (id_pipe[k])
    );
  end

  assign busy = (|vld_pipe) | (|rsp_valid);
endmodule
